arm_wb_display: RTL and testbench



---
 rtl/arm_wb_display.sv | 221 ++++++++++++++++++++++
 tb/tb_arm_wb_display.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/arm_wb_display.sv
// arm_wb_display: debug output path from the ARM core to the DE2 board.
// Register-writeback events from the core are captured into a small FIFO.
// Each debounced press of a pushbutton pops the oldest event onto the eight
// seven-segment digits and the green LEDs.
//
// Ports:
//   CLOCK_50   in   1   system clock (50 MHz)
//   RST_N      in   1   asynchronous active-low reset
//   wb_valid   in   1   core wrote a register this cycle
//   wb_reg     in   4   destination register index
//   wb_value   in  32   value written
//   key_n      in   1   raw pushbutton, active-low, asynchronous, bouncy
//   HEX0..HEX7 out  7   active-low segments {g,f,e,d,c,b,a}; HEXn = nibble n
//   LEDG       out  9   [3:0] FIFO count, [7:4] displayed reg, [8] overflow
//
// Handshake: wb_valid has no ready. An event is accepted on every cycle
// wb_valid=1 unless the FIFO is full and no pop happens in the same cycle;
// in that case the event is dropped and the sticky overflow flag is set.
//
// Debug: db_state (debouncer FSM state) and deb_cnt (debounce counter)
// are internal signals kept visible for checkers.
module arm_wb_display #(
  parameter int DEPTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        CLOCK_50,
  input  logic        RST_N,
  input  logic        wb_valid,
  input  logic [3:0]  wb_reg,
  input  logic [31:0] wb_value,
  input  logic        key_n,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7,
  output logic [8:0]  LEDG
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------
  // Key synchronizer (both flops reset high = key released)
  // ---------------------------------------------------------------------
  logic sync1, ks;

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= 1'b1;
      ks    <= 1'b1;
    end else begin
      sync1 <= key_n;
      ks    <= sync1;
    end
  end

  // ---------------------------------------------------------------------
  // Debouncer FSM. The accepted level d is encoded in the state:
  // RELEASED/PRESSING have d=1, HELD/RELEASING have d=0. The counter
  // runs only while ks disagrees with d.
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    PRESSING  = 2'd1,
    HELD      = 2'd2,
    RELEASING = 2'd3
  } deb_state_t;

  deb_state_t      db_state, db_state_next;
  logic [CW-1:0]   deb_cnt, deb_cnt_next;
  logic            deb_level;
  logic            pop, pop_next;

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      db_state <= RELEASED;
      deb_cnt  <= '0;
      pop      <= 1'b0;
    end else begin
      db_state <= db_state_next;
      deb_cnt  <= deb_cnt_next;
      pop      <= pop_next;
    end
  end

  always_comb begin
    db_state_next = db_state;
    deb_cnt_next  = deb_cnt;
    pop_next      = 1'b0;
    deb_level     = (db_state == RELEASED) || (db_state == PRESSING);
    if (ks == deb_level) begin
      deb_cnt_next  = '0;
      db_state_next = deb_level ? RELEASED : HELD;
    end else if (deb_cnt == C_LAST) begin
      // Level change accepted; only the press direction produces a pop.
      deb_cnt_next  = '0;
      db_state_next = deb_level ? HELD : RELEASED;
      pop_next      = deb_level;
    end else begin
      deb_cnt_next  = deb_cnt + 1'b1;
      db_state_next = deb_level ? PRESSING : RELEASING;
    end
  end

  // ---------------------------------------------------------------------
  // FIFO of {reg, value}
  // ---------------------------------------------------------------------
  logic [35:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          overflow;
  logic          empty, full, pop_fire, push_fire;
  logic [35:0]   head;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign pop_fire  = pop && !empty;
  // A full FIFO still accepts a push when a pop frees a slot this cycle.
  assign push_fire = wb_valid && (!full || pop_fire);
  assign head      = mem[rd_ptr];

  always_ff @(posedge CLOCK_50) begin
    if (push_fire) begin
      mem[wr_ptr] <= {wb_reg, wb_value};
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
      if (push_fire && !pop_fire)      count <= count + 1'b1;
      else if (pop_fire && !push_fire) count <= count - 1'b1;
      if (wb_valid && !push_fire) overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Display registers
  // ---------------------------------------------------------------------
  logic [31:0] disp_value;
  logic [3:0]  disp_reg;
  logic        disp_valid;

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      disp_value <= '0;
      disp_reg   <= '0;
      disp_valid <= 1'b0;
    end else if (pop_fire) begin
      disp_value <= head[31:0];
      disp_reg   <= head[35:32];
      disp_valid <= 1'b1;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    HEX0 = 7'h7F;
    HEX1 = 7'h7F;
    HEX2 = 7'h7F;
    HEX3 = 7'h7F;
    HEX4 = 7'h7F;
    HEX5 = 7'h7F;
    HEX6 = 7'h7F;
    HEX7 = 7'h7F;
    if (disp_valid) begin
      HEX0 = seg7(disp_value[3:0]);
      HEX1 = seg7(disp_value[7:4]);
      HEX2 = seg7(disp_value[11:8]);
      HEX3 = seg7(disp_value[15:12]);
      HEX4 = seg7(disp_value[19:16]);
      HEX5 = seg7(disp_value[23:20]);
      HEX6 = seg7(disp_value[27:24]);
      HEX7 = seg7(disp_value[31:28]);
    end
  end

  // Count shown on four LEDs; saturates only if DEPTH exceeds 15.
  logic [3:0] led_cnt;

  always_comb begin
    if (int'(count) > 15) led_cnt = 4'hF;
    else                  led_cnt = 4'(count);
  end

  assign LEDG = {overflow, disp_reg, led_cnt};

endmodule

// File: tb/tb_arm_wb_display.sv
module tb_arm_wb_display;

  localparam int DEPTH = 8;
  localparam int DEB   = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [3:0]  wb_reg;
  logic [31:0] wb_value;
  logic        key_n;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic [8:0]  ledg;
  logic [55:0] hex_all;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign hex_all = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

  arm_wb_display #(
    .DEPTH           (DEPTH),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .CLOCK_50 (clk),
    .RST_N    (rst_n),
    .wb_valid (wb_valid),
    .wb_reg   (wb_reg),
    .wb_value (wb_value),
    .key_n    (key_n),
    .HEX0     (hex0),
    .HEX1     (hex1),
    .HEX2     (hex2),
    .HEX3     (hex3),
    .HEX4     (hex4),
    .HEX5     (hex5),
    .HEX6     (hex6),
    .HEX7     (hex7),
    .LEDG     (ledg)
  );

  // Hand-copied glyph table, active-low {g,f,e,d,c,b,a}.
  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  localparam logic [55:0] BLANK = {8{7'h7F}};

  function automatic logic [55:0] hex_exp(input logic [31:0] v);
    logic [55:0] r;
    logic [3:0]  nib;
    for (int n = 0; n < 8; n++) begin
      nib = v[4*n +: 4];
      r[7*n +: 7] = glyph[nib];
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic push(input logic [3:0] r, input logic [31:0] v);
    wb_valid = 1'b1;
    wb_reg   = r;
    wb_value = v;
    tick();
    wb_valid = 1'b0;
  endtask

  // Press long enough for the display to update, then release fully.
  task automatic press();
    key_n = 1'b0;
    repeat (DEB + 3) tick();
    key_n = 1'b1;
    repeat (DEB + 4) tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n    = 1'b0;
    wb_valid = 1'b0;
    wb_reg   = '0;
    wb_value = '0;
    key_n    = 1'b1;
    repeat (3) tick();

    // 1. reset state
    check("rst_hex", hex_all, BLANK);
    check("rst_ledg", ledg, 9'h000);
    check("rst_state", dut.db_state, 2'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_hex", hex_all, BLANK);
    check("idle_ledg", ledg, 9'h000);

    // 2. two pushes, two presses (first press also checks latency)
    push(4'd1, 32'h12345678);
    check("push1_ledg", ledg, 9'h001);
    push(4'd2, 32'hDEADBEEF);
    check("push2_ledg", ledg, 9'h002);
    key_n = 1'b0;
    repeat (DEB + 2) tick();
    check("lat_before_hex", hex_all, BLANK);
    check("lat_before_ledg", ledg, 9'h002);
    tick();
    check("press1_hex", hex_all, hex_exp(32'h12345678));
    check("press1_ledg", ledg, 9'h011);
    repeat (20) tick();
    check("hold_no_repop", ledg, 9'h011);
    key_n = 1'b1;
    repeat (DEB + 4) tick();
    press();
    check("press2_hex", hex_all, hex_exp(32'hDEADBEEF));
    check("press2_ledg", ledg, 9'h020);

    // 3. bounce: low 3, high 4, low 2 -> nothing accepted
    key_n = 1'b0; repeat (3) tick();
    key_n = 1'b1; repeat (4) tick();
    key_n = 1'b0; repeat (2) tick();
    key_n = 1'b1; repeat (DEB + 4) tick();
    check("bounce_hex", hex_all, hex_exp(32'hDEADBEEF));
    check("bounce_ledg", ledg, 9'h020);
    check("bounce_cnt", dut.deb_cnt, 0);
    check("bounce_state", dut.db_state, 2'd0);

    // 4. overflow: nine pushes into eight slots
    for (int i = 0; i < 9; i++) push(4'(i + 3), 32'(i));
    check("ovf_ledg", ledg, 9'h128);
    for (int j = 0; j < 8; j++) begin
      press();
      check($sformatf("ovf_pop%0d_hex", j), hex_all, hex_exp(32'(j)));
      check($sformatf("ovf_pop%0d_ledg", j), ledg, {1'b1, 4'(j + 3), 4'(7 - j)});
    end
    // FIFO now empty: popping must hold value 7, never show 8.
    press();
    check("empty_pop_hex", hex_all, hex_exp(32'd7));
    check("empty_pop_ledg", ledg, 9'h1A0);

    // 5. full with simultaneous push and pop
    rst_n = 1'b0;
    tick();
    check("rst2_ledg", ledg, 9'h000);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) push(4'(i + 1), 32'h100 + 32'(i));
    check("full_ledg", ledg, 9'h008);
    key_n = 1'b0;
    repeat (DEB + 2) tick();
    // Pop pulse is high this cycle; push lands on the same edge.
    wb_valid = 1'b1;
    wb_reg   = 4'hA;
    wb_value = 32'hAAAA5555;
    tick();
    wb_valid = 1'b0;
    check("simul_hex", hex_all, hex_exp(32'h100));
    check("simul_ledg", ledg, 9'h018);
    key_n = 1'b1;
    repeat (DEB + 4) tick();
    for (int k = 1; k < 8; k++) begin
      press();
      check($sformatf("simul_pop%0d_hex", k), hex_all, hex_exp(32'h100 + 32'(k)));
      check($sformatf("simul_pop%0d_ledg", k), ledg, {1'b0, 4'(k + 1), 4'(8 - k)});
    end
    press();
    check("wrap_hex", hex_all, hex_exp(32'hAAAA5555));
    check("wrap_ledg", ledg, 9'h0A0);

    // 6. empty pop, then reset mid-debounce
    press();
    check("empty2_hex", hex_all, hex_exp(32'hAAAA5555));
    check("empty2_ledg", ledg, 9'h0A0);
    key_n = 1'b0;
    repeat (4) tick();
    check("mid_cnt", dut.deb_cnt, 2);
    check("mid_state", dut.db_state, 2'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_hex", hex_all, BLANK);
    check("async_rst_ledg", ledg, 9'h000);
    check("async_rst_state", dut.db_state, 2'd0);
    check("async_rst_cnt", dut.deb_cnt, 0);
    key_n = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    check("post_rst_hex", hex_all, BLANK);
    check("post_rst_ledg", ledg, 9'h000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
